// File: rtl/serial_parallel_loader_if.sv
// Bundle between the host byte stream, the loader and the two memory write ports.
// Latency: none (wires only).
// Backpressure: byte_valid/byte_ready handshake; the memory write ports cannot stall.
//
// Port summary
//   host -> loader : start, inst_count, data_count, byte_in, byte_valid
//   loader -> host : byte_ready, busy, finish
//   loader -> mems : we/data/address for the instruction and data memories
interface serial_parallel_loader_if #(
    parameter int INST_W = 15,
    parameter int DATA_W = 128,
    parameter int ADDR_W = 8
) ();
    logic              start;
    logic [ADDR_W-1:0] inst_count;
    logic [ADDR_W-1:0] data_count;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              we_inst_mem;
    logic [INST_W-1:0] data_inst_mem;
    logic [ADDR_W-1:0] address_inst_mem;
    logic              we_data_mem;
    logic [DATA_W-1:0] data_data_mem;
    logic [ADDR_W-1:0] address_data_mem;
    logic              busy;
    logic              finish;

    // Host / testbench side.
    modport master (
        output start, inst_count, data_count, byte_in, byte_valid,
        input  byte_ready, we_inst_mem, data_inst_mem, address_inst_mem,
        input  we_data_mem, data_data_mem, address_data_mem, busy, finish
    );

    // Loader side.
    modport slave (
        input  start, inst_count, data_count, byte_in, byte_valid,
        output byte_ready, we_inst_mem, data_inst_mem, address_inst_mem,
        output we_data_mem, data_data_mem, address_data_mem, busy, finish
    );
endinterface

// File: rtl/serial_parallel_loader.sv
// Assembles a byte-serial host stream into instruction words then data words and writes them to memory.
// Latency: write strobe 1 cycle after the accepting edge of a word's final byte.
// Backpressure: byte_ready high only while loading; host stalls by dropping byte_valid, partial words are held.
//
// Port summary
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : serial_parallel_loader_if.slave (host stream, memory write ports, busy/finish)
module serial_parallel_loader #(
    parameter int INST_W = 15,
    parameter int DATA_W = 128,
    parameter int ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    serial_parallel_loader_if.slave  bus
);
    localparam int DATA_BYTES = DATA_W / 8;
    localparam int BIDX_W     = $clog2(DATA_BYTES);
    localparam logic [BIDX_W-1:0] LAST_DATA_BYTE = BIDX_W'(DATA_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_INST = 2'd1,
        LOAD_DATA = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   inst_cnt_q;
    logic [ADDR_W-1:0]   data_cnt_q;
    logic [ADDR_W-1:0]   word_idx;
    logic [BIDX_W-1:0]   byte_idx;
    logic [7:0]          inst_lo;
    logic [DATA_W-1:0]   data_asm;
    logic [DATA_W-1:0]   data_next;

    logic                busy_q;
    logic                finish_q;
    logic                we_inst_q;
    logic [INST_W-1:0]   data_inst_q;
    logic [ADDR_W-1:0]   addr_inst_q;
    logic                we_data_q;
    logic [DATA_W-1:0]   data_data_q;
    logic [ADDR_W-1:0]   addr_data_q;

    logic                accept;
    logic                last_inst_word;
    logic                last_data_word;

    // busy_q tracks LOAD_INST/LOAD_DATA exactly, so it doubles as byte_ready.
    assign accept         = bus.byte_valid && busy_q;
    assign last_inst_word = (word_idx == inst_cnt_q - ADDR_W'(1));
    assign last_data_word = (word_idx == data_cnt_q - ADDR_W'(1));

    // Data word with the incoming byte merged in at its little-endian slot; on the
    // final byte this is the complete word, so it can go straight to the output.
    always_comb begin
        data_next = data_asm;
        data_next[{byte_idx, 3'b000} +: 8] = bus.byte_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            inst_cnt_q  <= '0;
            data_cnt_q  <= '0;
            word_idx    <= '0;
            byte_idx    <= '0;
            inst_lo     <= '0;
            data_asm    <= '0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
            we_inst_q   <= 1'b0;
            data_inst_q <= '0;
            addr_inst_q <= '0;
            we_data_q   <= 1'b0;
            data_data_q <= '0;
            addr_data_q <= '0;
        end else begin
            // Strobes are single-cycle; data/address registers hold their last value.
            we_inst_q <= 1'b0;
            we_data_q <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        inst_cnt_q <= bus.inst_count;
                        data_cnt_q <= bus.data_count;
                        word_idx   <= '0;
                        byte_idx   <= '0;
                        if (bus.inst_count != '0) begin
                            state    <= LOAD_INST;
                            busy_q   <= 1'b1;
                            finish_q <= 1'b0;
                        end else if (bus.data_count != '0) begin
                            state    <= LOAD_DATA;
                            busy_q   <= 1'b1;
                            finish_q <= 1'b0;
                        end else begin
                            // Nothing to load: straight to DONE, finish re-asserts at once.
                            state    <= DONE;
                            busy_q   <= 1'b0;
                            finish_q <= 1'b1;
                        end
                    end
                end

                LOAD_INST: begin
                    if (accept) begin
                        if (byte_idx == '0) begin
                            inst_lo  <= bus.byte_in;
                            byte_idx <= BIDX_W'(1);
                        end else begin
                            // Top bit of the high byte does not fit in the word and is dropped.
                            we_inst_q   <= 1'b1;
                            data_inst_q <= {bus.byte_in[INST_W-9:0], inst_lo};
                            addr_inst_q <= word_idx;
                            byte_idx    <= '0;
                            if (last_inst_word) begin
                                word_idx <= '0;
                                if (data_cnt_q != '0) begin
                                    state <= LOAD_DATA;
                                end else begin
                                    state    <= DONE;
                                    busy_q   <= 1'b0;
                                    finish_q <= 1'b1;
                                end
                            end else begin
                                word_idx <= word_idx + ADDR_W'(1);
                            end
                        end
                    end
                end

                LOAD_DATA: begin
                    if (accept) begin
                        data_asm <= data_next;
                        if (byte_idx == LAST_DATA_BYTE) begin
                            we_data_q   <= 1'b1;
                            data_data_q <= data_next;
                            addr_data_q <= word_idx;
                            byte_idx    <= '0;
                            if (last_data_word) begin
                                word_idx <= '0;
                                state    <= DONE;
                                busy_q   <= 1'b0;
                                finish_q <= 1'b1;
                            end else begin
                                word_idx <= word_idx + ADDR_W'(1);
                            end
                        end else begin
                            byte_idx <= byte_idx + BIDX_W'(1);
                        end
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_ready       = busy_q;
    assign bus.busy             = busy_q;
    assign bus.finish           = finish_q;
    assign bus.we_inst_mem      = we_inst_q;
    assign bus.data_inst_mem    = data_inst_q;
    assign bus.address_inst_mem = addr_inst_q;
    assign bus.we_data_mem      = we_data_q;
    assign bus.data_data_mem    = data_data_q;
    assign bus.address_data_mem = addr_data_q;
endmodule
